// File: rtl/commit_mon_pkg.sv
// Shared types and width helpers for the commit/halt monitor.
package commit_mon_pkg;

  // Monitor FSM states; encodings are exported on mon_state for debug.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    CONFIRM = 3'd1,
    DRAIN   = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } mon_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// Popcount and exclusive prefix sums over the per-lane commit valids.
module lane_prefix_count #(
  parameter int LANES = 1,
  parameter int CW    = 1
) (
  input  logic [LANES-1:0]    valid,
  output logic [LANES*CW-1:0] prefix,
  output logic [CW-1:0]       total
);

  logic [CW-1:0] acc;

  // Walk the lanes in index order: each lane sees the count of valid lanes below it.
  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < LANES; i++) begin
      prefix[i*CW +: CW] = acc;
      acc                = acc + CW'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/commit_halt_monitor.sv
// Multi-lane commit counter with self-loop halt detection and no-commit watchdog.
module commit_halt_monitor
  import commit_mon_pkg::*;
#(
  parameter int LANES          = 1,
  parameter int XLEN           = 32,
  parameter int ORDER_W        = 64,
  parameter int HALT_CONFIRM   = 2,
  parameter int DRAIN_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         commit_valid,
  input  logic [LANES*XLEN-1:0]    commit_pc,
  input  logic [LANES*XLEN-1:0]    commit_next_pc,
  output logic [LANES*ORDER_W-1:0] lane_order,
  output logic [ORDER_W-1:0]       commit_count,
  output logic                     halt,
  output logic                     timeout,
  output logic [2:0]               mon_state
);

  localparam int CW    = cnt_width(LANES);
  localparam int CNF_W = cnt_width(HALT_CONFIRM);
  localparam int DRN_W = cnt_width(DRAIN_CYCLES);
  localparam int IDL_W = cnt_width(TIMEOUT_CYCLES);

  // Terminal values compared against the pre-increment counter.
  localparam logic [CNF_W-1:0] CNF_LAST = CNF_W'(HALT_CONFIRM - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  mon_state_e         state_q, state_d;
  logic [CNF_W-1:0]   confirm_cnt_q, confirm_cnt_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [IDL_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [ORDER_W-1:0] commit_count_q, commit_count_d;
  logic               halt_q, halt_d;
  logic               timeout_q, timeout_d;

  logic [LANES*CW-1:0] prefix;
  logic [CW-1:0]       total;
  logic [LANES-1:0]    loop_lanes, prog_lanes;
  logic                is_loop, is_prog, is_idle, wd_fire, confirm_done;

  lane_prefix_count #(
    .LANES (LANES),
    .CW    (CW)
  ) u_prefix (
    .valid  (commit_valid),
    .prefix (prefix),
    .total  (total)
  );

  // Per-lane order numbers relative to the registered running count.
  always_comb begin
    lane_order = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_order[i*ORDER_W +: ORDER_W] = commit_count_q + ORDER_W'(prefix[i*CW +: CW]);
    end
  end

  // Classify each lane and the cycle as a whole; progress outranks loop.
  always_comb begin
    loop_lanes = '0;
    prog_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      loop_lanes[i] = commit_valid[i] & (commit_next_pc[i*XLEN +: XLEN] == commit_pc[i*XLEN +: XLEN]);
      prog_lanes[i] = commit_valid[i] & (commit_next_pc[i*XLEN +: XLEN] != commit_pc[i*XLEN +: XLEN]);
    end
    is_prog = |prog_lanes;
    is_loop = (|loop_lanes) & ~is_prog;
    is_idle = ~(|commit_valid);
    wd_fire = (TIMEOUT_CYCLES != 0) && is_idle && (idle_cnt_q == IDL_LAST);
  end

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d        = state_q;
    confirm_cnt_d  = confirm_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    commit_count_d = commit_count_q;
    confirm_done   = 1'b0;

    if ((state_q == HALTED) || (state_q == TIMEOUT)) begin
      commit_count_d = commit_count_q;
    end else begin
      commit_count_d = commit_count_q + ORDER_W'(total);
    end

    case (state_q)
      RUN: begin
        if (is_loop) begin
          idle_cnt_d = '0;
          if (HALT_CONFIRM == 1) begin
            confirm_done = 1'b1;
          end else begin
            state_d       = CONFIRM;
            confirm_cnt_d = CNF_W'(1);
          end
        end else if (is_idle) begin
          if (wd_fire) begin
            state_d = TIMEOUT;
          end else if (TIMEOUT_CYCLES != 0) begin
            idle_cnt_d = idle_cnt_q + IDL_W'(1);
          end else begin
            idle_cnt_d = '0;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      CONFIRM: begin
        if (is_prog) begin
          state_d       = RUN;
          confirm_cnt_d = '0;
          idle_cnt_d    = '0;
        end else if (is_loop) begin
          idle_cnt_d = '0;
          if (confirm_cnt_q == CNF_LAST) begin
            confirm_done = 1'b1;
          end else begin
            confirm_cnt_d = confirm_cnt_q + CNF_W'(1);
          end
        end else begin
          // Stalls keep the loop evidence; only the watchdog advances.
          if (wd_fire) begin
            state_d = TIMEOUT;
          end else if (TIMEOUT_CYCLES != 0) begin
            idle_cnt_d = idle_cnt_q + IDL_W'(1);
          end else begin
            idle_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        idle_cnt_d = '0;
        if (is_prog) begin
          // Code moved on after all: abandon the halt.
          state_d       = RUN;
          confirm_cnt_d = '0;
          drain_cnt_d   = '0;
        end else if (drain_cnt_q == DRN_LAST) begin
          state_d     = HALTED;
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (confirm_done) begin
      confirm_cnt_d = CNF_W'(HALT_CONFIRM);
      drain_cnt_d   = '0;
      if (DRAIN_CYCLES == 0) begin
        state_d = HALTED;
      end else begin
        state_d = DRAIN;
      end
    end else begin
      confirm_cnt_d = confirm_cnt_d;
    end

    halt_d    = (state_d == HALTED);
    timeout_d = (state_d == TIMEOUT);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      confirm_cnt_q  <= '0;
      drain_cnt_q    <= '0;
      idle_cnt_q     <= '0;
      commit_count_q <= '0;
      halt_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      confirm_cnt_q  <= confirm_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      commit_count_q <= commit_count_d;
      halt_q         <= halt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign commit_count = commit_count_q;
  assign halt         = halt_q;
  assign timeout      = timeout_q;
  assign mon_state    = state_q;

endmodule

// File: tb/tb_commit_halt_monitor.sv
// Directed bench for commit_halt_monitor across four parameterisations.
module tb_commit_halt_monitor;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: LANES=2 HALT_CONFIRM=2 DRAIN_CYCLES=1 default watchdog
  logic [1:0]   a_v;
  logic [63:0]  a_pc, a_npc, a_cnt;
  logic [127:0] a_lo;
  logic         a_halt, a_to;
  logic [2:0]   a_st;
  // b: LANES=1 HALT_CONFIRM=1 DRAIN_CYCLES=1 TIMEOUT_CYCLES=8
  logic         b_v;
  logic [31:0]  b_pc, b_npc;
  logic [63:0]  b_lo, b_cnt;
  logic         b_halt, b_to;
  logic [2:0]   b_st;
  // c: LANES=1 HALT_CONFIRM=1 DRAIN_CYCLES=4 TIMEOUT_CYCLES=0
  logic         c_v;
  logic [31:0]  c_pc, c_npc;
  logic [63:0]  c_lo, c_cnt;
  logic         c_halt, c_to;
  logic [2:0]   c_st;
  // d: LANES=1 HALT_CONFIRM=3 DRAIN_CYCLES=1 TIMEOUT_CYCLES=0
  logic         d_v;
  logic [31:0]  d_pc, d_npc;
  logic [63:0]  d_lo, d_cnt;
  logic         d_halt, d_to;
  logic [2:0]   d_st;

  commit_halt_monitor #(.LANES(2), .HALT_CONFIRM(2), .DRAIN_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .commit_valid(a_v), .commit_pc(a_pc), .commit_next_pc(a_npc),
    .lane_order(a_lo), .commit_count(a_cnt), .halt(a_halt), .timeout(a_to), .mon_state(a_st));
  commit_halt_monitor #(.LANES(1), .HALT_CONFIRM(1), .DRAIN_CYCLES(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .commit_valid(b_v), .commit_pc(b_pc), .commit_next_pc(b_npc),
    .lane_order(b_lo), .commit_count(b_cnt), .halt(b_halt), .timeout(b_to), .mon_state(b_st));
  commit_halt_monitor #(.LANES(1), .HALT_CONFIRM(1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .commit_valid(c_v), .commit_pc(c_pc), .commit_next_pc(c_npc),
    .lane_order(c_lo), .commit_count(c_cnt), .halt(c_halt), .timeout(c_to), .mon_state(c_st));
  commit_halt_monitor #(.LANES(1), .HALT_CONFIRM(3), .DRAIN_CYCLES(1), .TIMEOUT_CYCLES(0)) u_d (
    .clk(clk), .rst(rst), .commit_valid(d_v), .commit_pc(d_pc), .commit_next_pc(d_npc),
    .lane_order(d_lo), .commit_count(d_cnt), .halt(d_halt), .timeout(d_to), .mon_state(d_st));

  // Two reset edges with all inputs idle; returns at a falling edge with rst released.
  task do_reset;
    @(negedge clk);
    rst = 1'b0;
    a_v = 2'b00; a_pc = 64'h0; a_npc = 64'h0;
    b_v = 1'b0;  b_pc = 32'h0; b_npc = 32'h0;
    c_v = 1'b0;  c_pc = 32'h0; c_npc = 32'h0;
    d_v = 1'b0;  d_pc = 32'h0; d_npc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task test_reset;
    do_reset;
    checks++; if (a_cnt !== 64'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", a_cnt); end
    checks++; if (a_halt !== 1'b0) begin failures++; $display("FAIL reset_halt actual=%0b expected=0", a_halt); end
    checks++; if (a_to !== 1'b0) begin failures++; $display("FAIL reset_timeout actual=%0b expected=0", a_to); end
    checks++; if (a_st !== 3'd0) begin failures++; $display("FAIL reset_state actual=%0d expected=0", a_st); end
  endtask

  task test_order;
    do_reset;
    @(negedge clk);
    a_v = 2'b11; a_pc = {32'h104, 32'h100}; a_npc = {32'h108, 32'h104};
    #2;
    checks++; if (a_lo[63:0] !== 64'd0) begin failures++; $display("FAIL order_c0_l0 actual=%0d expected=0", a_lo[63:0]); end
    checks++; if (a_lo[127:64] !== 64'd1) begin failures++; $display("FAIL order_c0_l1 actual=%0d expected=1", a_lo[127:64]); end
    @(negedge clk);
    checks++; if (a_cnt !== 64'd2) begin failures++; $display("FAIL order_count1 actual=%0d expected=2", a_cnt); end
    a_v = 2'b01;
    #2;
    checks++; if (a_lo[63:0] !== 64'd2) begin failures++; $display("FAIL order_c1_l0 actual=%0d expected=2", a_lo[63:0]); end
    @(negedge clk);
    a_v = 2'b10;
    #2;
    checks++; if (a_lo[127:64] !== 64'd3) begin failures++; $display("FAIL order_c2_l1 actual=%0d expected=3", a_lo[127:64]); end
    @(negedge clk);
    a_v = 2'b11;
    #2;
    checks++; if (a_lo[63:0] !== 64'd4) begin failures++; $display("FAIL order_c3_l0 actual=%0d expected=4", a_lo[63:0]); end
    checks++; if (a_lo[127:64] !== 64'd5) begin failures++; $display("FAIL order_c3_l1 actual=%0d expected=5", a_lo[127:64]); end
    @(negedge clk);
    a_v = 2'b00;
    checks++; if (a_cnt !== 64'd6) begin failures++; $display("FAIL order_count4 actual=%0d expected=6", a_cnt); end
    checks++; if (a_st !== 3'd0) begin failures++; $display("FAIL order_state actual=%0d expected=0", a_st); end
  endtask

  task test_mixed_lanes;
    do_reset;
    @(negedge clk);
    a_v = 2'b11; a_pc = {32'h84, 32'h80}; a_npc = {32'h88, 32'h80};
    @(negedge clk);
    checks++; if (a_st !== 3'd0) begin failures++; $display("FAIL mixed_stays_run actual=%0d expected=0", a_st); end
    a_v = 2'b01;
    @(negedge clk);
    checks++; if (a_st !== 3'd1) begin failures++; $display("FAIL mixed_loop_confirm actual=%0d expected=1", a_st); end
    a_v = 2'b00;
    @(negedge clk);
    checks++; if (a_st !== 3'd1) begin failures++; $display("FAIL mixed_idle_hold actual=%0d expected=1", a_st); end
    a_v = 2'b01;
    @(negedge clk);
    checks++; if (a_st !== 3'd2) begin failures++; $display("FAIL mixed_drain actual=%0d expected=2", a_st); end
    a_v = 2'b00;
    @(negedge clk);
    checks++; if (a_st !== 3'd3) begin failures++; $display("FAIL mixed_halted actual=%0d expected=3", a_st); end
    checks++; if (a_halt !== 1'b1) begin failures++; $display("FAIL mixed_halt actual=%0b expected=1", a_halt); end
    checks++; if (a_cnt !== 64'd4) begin failures++; $display("FAIL mixed_count actual=%0d expected=4", a_cnt); end
  endtask

  task test_basic_halt;
    do_reset;
    @(negedge clk);
    b_v = 1'b1; b_pc = 32'h60; b_npc = 32'h60;
    checks++; if (b_halt !== 1'b0) begin failures++; $display("FAIL halt_t0 actual=%0b expected=0", b_halt); end
    @(negedge clk);
    checks++; if (b_halt !== 1'b0) begin failures++; $display("FAIL halt_t1 actual=%0b expected=0", b_halt); end
    checks++; if (b_st !== 3'd2) begin failures++; $display("FAIL halt_t1_state actual=%0d expected=2", b_st); end
    @(negedge clk);
    checks++; if (b_halt !== 1'b1) begin failures++; $display("FAIL halt_t2 actual=%0b expected=1", b_halt); end
    checks++; if (b_st !== 3'd3) begin failures++; $display("FAIL halt_t2_state actual=%0d expected=3", b_st); end
    checks++; if (b_cnt !== 64'd2) begin failures++; $display("FAIL halt_t2_count actual=%0d expected=2", b_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (b_halt !== 1'b1) begin failures++; $display("FAIL halt_sticky actual=%0b expected=1", b_halt); end
    checks++; if (b_cnt !== 64'd2) begin failures++; $display("FAIL halt_frozen_count actual=%0d expected=2", b_cnt); end
    b_v = 1'b0;
  endtask

  task test_false_loop;
    do_reset;
    @(negedge clk);
    d_v = 1'b1; d_pc = 32'h60; d_npc = 32'h60;
    @(negedge clk);
    checks++; if (d_st !== 3'd1) begin failures++; $display("FAIL false_l1 actual=%0d expected=1", d_st); end
    @(negedge clk);
    checks++; if (d_st !== 3'd1) begin failures++; $display("FAIL false_l2 actual=%0d expected=1", d_st); end
    d_pc = 32'h64; d_npc = 32'h68;
    @(negedge clk);
    checks++; if (d_st !== 3'd0) begin failures++; $display("FAIL false_back_run actual=%0d expected=0", d_st); end
    checks++; if (d_halt !== 1'b0) begin failures++; $display("FAIL false_no_halt actual=%0b expected=0", d_halt); end
    d_pc = 32'h60; d_npc = 32'h60;
    @(negedge clk);
    checks++; if (d_st !== 3'd1) begin failures++; $display("FAIL false_r1 actual=%0d expected=1", d_st); end
    @(negedge clk);
    checks++; if (d_st !== 3'd1) begin failures++; $display("FAIL false_r2 actual=%0d expected=1", d_st); end
    @(negedge clk);
    checks++; if (d_st !== 3'd2) begin failures++; $display("FAIL false_r3_drain actual=%0d expected=2", d_st); end
    d_v = 1'b0;
    @(negedge clk);
    checks++; if (d_halt !== 1'b1) begin failures++; $display("FAIL false_final_halt actual=%0b expected=1", d_halt); end
  endtask

  task test_watchdog;
    do_reset;
    repeat (7) @(negedge clk);
    checks++; if (b_to !== 1'b0) begin failures++; $display("FAIL wd_early actual=%0b expected=0", b_to); end
    @(negedge clk);
    checks++; if (b_to !== 1'b1) begin failures++; $display("FAIL wd_expire actual=%0b expected=1", b_to); end
    checks++; if (b_halt !== 1'b0) begin failures++; $display("FAIL wd_halt actual=%0b expected=0", b_halt); end
    checks++; if (b_st !== 3'd4) begin failures++; $display("FAIL wd_state actual=%0d expected=4", b_st); end
    repeat (1000) @(negedge clk);
    checks++; if (b_to !== 1'b1) begin failures++; $display("FAIL wd_sticky actual=%0b expected=1", b_to); end
    checks++; if (c_to !== 1'b0) begin failures++; $display("FAIL wd_disabled_c actual=%0b expected=0", c_to); end
    checks++; if (d_to !== 1'b0) begin failures++; $display("FAIL wd_disabled_d actual=%0b expected=0", d_to); end
    checks++; if (c_st !== 3'd0) begin failures++; $display("FAIL wd_disabled_state actual=%0d expected=0", c_st); end
  endtask

  task test_reset_in_drain;
    do_reset;
    @(negedge clk);
    c_v = 1'b1; c_pc = 32'h70; c_npc = 32'h70;
    @(negedge clk);
    checks++; if (c_st !== 3'd2) begin failures++; $display("FAIL rd_drain actual=%0d expected=2", c_st); end
    c_v = 1'b0;
    @(negedge clk);
    checks++; if (c_cnt !== 64'd1) begin failures++; $display("FAIL rd_count actual=%0d expected=1", c_cnt); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (c_st !== 3'd0) begin failures++; $display("FAIL rd_state actual=%0d expected=0", c_st); end
    checks++; if (c_cnt !== 64'd0) begin failures++; $display("FAIL rd_count_clr actual=%0d expected=0", c_cnt); end
    checks++; if (c_halt !== 1'b0) begin failures++; $display("FAIL rd_halt actual=%0b expected=0", c_halt); end
    // Full four-cycle drain after the reset
    c_v = 1'b1;
    @(negedge clk);
    c_v = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (c_st !== 3'd2) begin failures++; $display("FAIL rd_drain4_mid actual=%0d expected=2", c_st); end
    checks++; if (c_halt !== 1'b0) begin failures++; $display("FAIL rd_drain4_nohalt actual=%0b expected=0", c_halt); end
    @(negedge clk);
    checks++; if (c_halt !== 1'b1) begin failures++; $display("FAIL rd_drain4_halt actual=%0b expected=1", c_halt); end
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired required=finished");
    $fatal(1, "time limit");
  end

  // Run the scenarios in order and report.
  initial begin
    rst = 1'b0;
    a_v = 2'b00; a_pc = 64'h0; a_npc = 64'h0;
    b_v = 1'b0;  b_pc = 32'h0; b_npc = 32'h0;
    c_v = 1'b0;  c_pc = 32'h0; c_npc = 32'h0;
    d_v = 1'b0;  d_pc = 32'h0; d_npc = 32'h0;
    test_reset;
    test_order;
    test_mixed_lanes;
    test_basic_halt;
    test_false_loop;
    test_watchdog;
    test_reset_in_drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_halt_monitor.md
Name: commit_halt_monitor

Overview:
- Parametrised successor to the single-lane commit/halt logic in the mp3 bench top.
- Counts committed instructions across LANES commit ports and assigns a per-lane order number.
- Detects a self-loop program end (next PC == PC). Raises halt after a configurable confirm and drain period.
- Adds a no-commit watchdog. Sits in hvl between the DUT probe signals and the rvfi interface; also usable in RTL as a debug block.

Parameters:
- LANES, 1, number of commit ports per cycle (1..4)
- XLEN, 32, PC width
- ORDER_W, 64, width of the order counter; wraps modulo 2^ORDER_W
- HALT_CONFIRM, 2, consecutive loop-commit cycles required before draining (>=1)
- DRAIN_CYCLES, 1, cycles to wait after confirm before halt, for final writeback (>=0)
- TIMEOUT_CYCLES, 100000, cycles without any commit before timeout; 0 disables the watchdog

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- commit_valid  input  LANES  lane i commits this cycle
- commit_pc  input  LANES*XLEN  PC of lane i instruction, lane i at [i*XLEN +: XLEN]
- commit_next_pc  input  LANES*XLEN  next PC of lane i
- lane_order  output  LANES*ORDER_W  order number of lane i commit this cycle
- commit_count  output  ORDER_W  registered total commits so far
- halt  output  1  sticky halt
- timeout  output  1  sticky watchdog expiry
- mon_state  output  3  current FSM state encoding, for debug

Behaviour:
- Reset values: commit_count=0, halt=0, timeout=0, state=RUN, confirm_cnt=0, drain_cnt=0, idle_cnt=0.
- lane_order[i] is combinational: commit_count + number of valid lanes with index < i. It is meaningful only when commit_valid[i]=1.
- commit_count update:
  - In RUN, CONFIRM and DRAIN, commit_count <= commit_count + popcount(commit_valid) each cycle, wrapping modulo 2^ORDER_W.
  - In HALTED and TIMEOUT, commit_count is frozen.
- Lane classification:
  - Lane is "loop" if valid and commit_next_pc==commit_pc.
  - Lane is "progress" if valid and the PCs differ.
- Cycle classification:
  - LOOP cycle: at least one loop lane and zero progress lanes.
  - PROGRESS cycle: at least one progress lane. Progress wins over loop in the same cycle.
  - IDLE cycle: no valid lanes.
- FSM states: RUN, CONFIRM, DRAIN, HALTED, TIMEOUT.
  - RUN:
    - LOOP cycle -> confirm_cnt=1.
    - If HALTCONFIRM==1, go to DRAIN; otherwise go to CONFIRM.
  - CONFIRM:
    - LOOP cycle increments confirm_cnt. Reaching HALT_CONFIRM -> DRAIN, drain_cnt=0.
    - PROGRESS cycle -> RUN, confirm_cnt=0.
    - IDLE cycle holds confirm_cnt; stalls do not break the loop.
  - DRAIN:
    - drain_cnt increments every cycle. At drain_cnt==DRAIN_CYCLES -> HALTED.
    - If DRAIN_CYCLES==0, go straight to HALTED on the cycle after confirm completes.
    - PROGRESS cycle -> RUN, with all counters cleared. A false halt is aborted.
  - HALTED: halt=1 (registered, asserted the cycle after entry), sticky until reset.
  - TIMEOUT: timeout=1, sticky until reset. halt stays 0.
- Watchdog:
  - idle_cnt increments on IDLE cycles in RUN/CONFIRM and clears on any valid commit.
  - idle_cnt==TIMEOUT_CYCLES-1 on an IDLE cycle -> TIMEOUT.
  - Inactive in DRAIN, HALTED, and when TIMEOUT_CYCLES==0.
- Simultaneous events:
  - Watchdog expiry and a LOOP cycle cannot coincide, since a LOOP cycle is not IDLE.
  - Reset has priority over every transition.
- Reset mid-operation: rst=0 in any state returns all state and outputs to reset values on that edge, including a halt in progress.
- Latency:
  - With HALT_CONFIRM=1 and DRAIN_CYCLES=1, halt rises 2 cycles after the first loop commit. This matches the legacy one-cycle writeback wait.

Decomposition:
- Package commit_mon_pkg holds:
  - FSM state enum mon_state_e: RUN=0, CONFIRM=1, DRAIN=2, HALTED=3, TIMEOUT=4.
  - localparam helper for counter widths, e.g. $clog2 of TIMEOUT_CYCLES+1.
- One sub-module, lane_prefix_count: combinational popcount plus exclusive prefix sums over commit_valid. It feeds lane_order and the count increment.

Test Plan:
- Order counting: LANES=2, valid patterns 11,01,10,11 from reset → lane_order {0,1},{2},{3},{4,5}; commit_count=6 after 4 cycles.
- Basic halt: LANES=1, HALT_CONFIRM=1, DRAIN_CYCLES=1, commit pc=0x60 next_pc=0x60 at cycle t → halt=1 at t+2 and stays 1 with commit_count frozen.
- False loop: HALT_CONFIRM=3, loop commits at t, t+1, then progress commit pc=0x64→0x68 at t+2 → mon_state returns to RUN and halt stays 0. Three further loop cycles → halt.
- Mixed lanes: LANES=2, lane0 loop (0x80→0x80), lane1 progress (0x84→0x88) in the same cycle → treated as PROGRESS, no CONFIRM entry.
- Watchdog: TIMEOUT_CYCLES=8, no commits after reset → timeout=1 after 8 idle cycles, halt=0. With TIMEOUT_CYCLES=0, 1000 idle cycles → timeout stays 0.
- Reset in DRAIN: DRAIN_CYCLES=4, rst=0 during drain → next cycle state=RUN, commit_count=0, halt=0.
